// File: rtl/toggle_pkg.sv
// ---------------------------------------------------------------------------
// toggle_pkg
// Shared constants and helpers for the toggle-encoded event line decoder.
//   SYNC_STAGES_DEFAULT : default synchronizer depth on the event line
//   MAX_PEND_DEFAULT    : default capacity of the pending-event counter
//   cnt_width()         : smallest counter width able to hold max_pend
// ---------------------------------------------------------------------------
package toggle_pkg;

    localparam int SYNC_STAGES_DEFAULT = 2;
    localparam int MAX_PEND_DEFAULT    = 15;

    // Width of a counter that must represent 0..max_pend inclusive.
    function automatic int cnt_width(input int max_pend);
        int w;
        w = $clog2(max_pend + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage : toggle_pkg

// File: rtl/sync_chain.sv
// ---------------------------------------------------------------------------
// sync_chain
// STAGES-deep flop synchronizer with synchronous active-high reset.
// Reused by the encoder-side test harness.
//   clk  : destination clock
//   rst  : synchronous, active-high reset (chain clears to 0)
//   d_i  : asynchronous input level
//   q_o  : synchronized level (last stage)
// ---------------------------------------------------------------------------
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    // NOTE: the chain is reset so that a line held high through reset is seen
    // as a defined 0->1 edge after release rather than an unknown start level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            // NOTE: non-blocking assignment makes every stage sample the old
            // value of its predecessor, giving a true shift by one per edge.
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule : sync_chain

// File: rtl/toggle_decoder.sv
// ---------------------------------------------------------------------------
// toggle_decoder
// Receive side of a toggle-encoded event line. Every level change on tog_in
// becomes one event: a one-cycle pulse plus an entry in a pending counter
// drained over a valid/ready handshake. Dropped events set a sticky flag.
//   clk         : system clock, all state on rising edge
//   rst         : synchronous, active-high reset
//   tog_in      : toggle-encoded event line, asynchronous to clk
//   tog_level   : synchronized level of tog_in
//   tog_level_n : inverse of tog_level
//   pulse_out   : one-cycle pulse per detected toggle
//   ev_valid    : at least one event pending
//   ev_ready    : consumer takes one event when ev_valid is high
//   pend_count  : number of pending events
//   overflow    : sticky, an event was dropped with the counter full
//   clr_ovf     : clears overflow on the next edge (a new overflow wins)
// ---------------------------------------------------------------------------
module toggle_decoder
    import toggle_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT,
    parameter int MAX_PEND    = MAX_PEND_DEFAULT,
    parameter int CNT_W       = cnt_width(MAX_PEND)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tog_in,
    output logic             tog_level,
    output logic             tog_level_n,
    output logic             pulse_out,
    output logic             ev_valid,
    input  logic             ev_ready,
    output logic [CNT_W-1:0] pend_count,
    output logic             overflow,
    input  logic             clr_ovf
);

    localparam logic [CNT_W-1:0] MAX_PEND_C = CNT_W'(MAX_PEND);
    localparam logic [CNT_W-1:0] ONE_C      = CNT_W'(1);

    logic             sync_level;
    logic             level_q;
    logic             pulse_q;
    logic             valid_q;
    logic             ovf_q;
    logic             ovf_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             inc;
    logic             dec;

    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (tog_in),
        .q_o (sync_level)
    );

    // The registered level doubles as the edge-detect history, so the edge,
    // pulse and counter all move on the same clock edge.
    assign inc = sync_level ^ level_q;
    // valid_q always mirrors count_q != 0, so dec can never underflow.
    assign dec = valid_q & ev_ready;

    always_comb begin
        // NOTE: defaults first so every path assigns count_d/ovf_d; without
        // them the partial if/else below would infer latches.
        count_d = count_q;
        ovf_d   = clr_ovf ? 1'b0 : ovf_q;
        if (inc && !dec) begin
            if (count_q == MAX_PEND_C) begin
                ovf_d = 1'b1;  // drop the event; set beats a same-cycle clear
            end else begin
                count_d = count_q + ONE_C;
            end
        end else if (dec && !inc) begin
            count_d = count_q - ONE_C;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            level_q <= 1'b0;
            pulse_q <= 1'b0;
            count_q <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            level_q <= sync_level;
            pulse_q <= inc;
            count_q <= count_d;
            // Registered from next-state so ev_valid matches pend_count in
            // the same cycle with no path from ev_ready.
            valid_q <= (count_d != '0);
            ovf_q   <= ovf_d;
        end
    end

    assign tog_level   = level_q;
    assign tog_level_n = ~level_q;
    assign pulse_out   = pulse_q;
    assign ev_valid    = valid_q;
    assign pend_count  = count_q;
    assign overflow    = ovf_q;

endmodule : toggle_decoder

// File: tb/tb_toggle_decoder.sv
// ---------------------------------------------------------------------------
// tb_toggle_decoder
// Self-checking bench for toggle_decoder. A behavioural model treats the
// decoder as a pure delay line on tog_in followed by an event queue with a
// bounded occupancy count; DUT outputs are compared against it every cycle.
// ---------------------------------------------------------------------------
module tb_toggle_decoder;

    localparam int SYNC_STAGES = 2;
    localparam int MAX_PEND    = 15;
    localparam int CNT_W       = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             tog_in;
    logic             tog_level;
    logic             tog_level_n;
    logic             pulse_out;
    logic             ev_valid;
    logic             ev_ready;
    logic [CNT_W-1:0] pend_count;
    logic             overflow;
    logic             clr_ovf;

    int n_checks = 0;
    int n_errors = 0;
    int pulses_seen;

    // Reference model state
    bit m_pipe[$];
    bit m_level;
    bit m_pulse;
    int m_count;
    bit m_valid;
    bit m_ovf;

    toggle_decoder #(
        .SYNC_STAGES (SYNC_STAGES),
        .MAX_PEND    (MAX_PEND),
        .CNT_W       (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tog_in      (tog_in),
        .tog_level   (tog_level),
        .tog_level_n (tog_level_n),
        .pulse_out   (pulse_out),
        .ev_valid    (ev_valid),
        .ev_ready    (ev_ready),
        .pend_count  (pend_count),
        .overflow    (overflow),
        .clr_ovf     (clr_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    // Model one rising edge with the inputs currently applied.
    task automatic model_step();
        bit inc;
        bit dec;
        bit nl;
        if (rst) begin
            m_pipe.delete();
            for (int i = 0; i < SYNC_STAGES; i++) m_pipe.push_back(1'b0);
            m_level = 0; m_pulse = 0; m_count = 0; m_valid = 0; m_ovf = 0;
        end else begin
            // tog_level after edge k is tog_in sampled SYNC_STAGES edges earlier
            m_pipe.push_back(tog_in);
            nl      = m_pipe.pop_front();
            inc     = (nl != m_level);
            m_level = nl;
            m_pulse = inc;
            dec     = m_valid && ev_ready;
            if (clr_ovf) m_ovf = 0;
            if (inc && !dec) begin
                if (m_count == MAX_PEND) m_ovf = 1;
                else m_count++;
            end else if (dec && !inc) begin
                m_count--;
            end
            m_valid = (m_count != 0);
        end
    endtask

    task automatic compare_all();
        check("tog_level",   int'(tog_level),   int'(m_level));
        check("tog_level_n", int'(tog_level_n), int'(!m_level));
        check("pulse_out",   int'(pulse_out),   int'(m_pulse));
        check("ev_valid",    int'(ev_valid),    int'(m_valid));
        check("pend_count",  int'(pend_count),  m_count);
        check("overflow",    int'(overflow),    int'(m_ovf));
    endtask

    // Apply inputs (at negedge), take one rising edge, compare at negedge.
    task automatic cycle(input bit t, input bit rdy, input bit clr, input bit r);
        tog_in   = t;
        ev_ready = rdy;
        clr_ovf  = clr;
        rst      = r;
        @(posedge clk);
        model_step();
        @(negedge clk);
        if (pulse_out) pulses_seen++;
        compare_all();
    endtask

    task automatic toggle(input bit rdy);
        cycle(!tog_in, rdy, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cycle(tog_in, rdy, 1'b0, 1'b0);
    endtask

    initial begin
        tog_in = 0; ev_ready = 0; clr_ovf = 0; rst = 1;
        for (int i = 0; i < SYNC_STAGES; i++) m_pipe.push_back(1'b0);
        @(negedge clk);

        // Reset and idle
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check("rst_level_n", int'(tog_level_n), 1);
        idle(20, 1'b0);
        check("idle_count", int'(pend_count), 0);

        // Single toggle: pulse exactly in the cycle after E0+2
        pulses_seen = 0;
        cycle(1'b1, 1'b0, 1'b0, 1'b0);             // E0
        check("lat_e0", int'(pulse_out), 0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);             // E0+1
        check("lat_e1", int'(pulse_out), 0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);             // E0+2
        check("lat_e2", int'(pulse_out), 1);
        check("lat_valid", int'(ev_valid), 1);
        idle(3, 1'b0);
        check("single_pulses", pulses_seen, 1);
        check("single_count", int'(pend_count), 1);
        check("single_level_n", int'(tog_level_n), 0);
        idle(1, 1'b1);
        check("single_drain", int'(pend_count), 0);
        check("single_valid", int'(ev_valid), 0);

        // Back-to-back toggles
        pulses_seen = 0;
        for (int i = 0; i < 4; i++) toggle(1'b0);
        idle(4, 1'b0);
        check("b2b_pulses", pulses_seen, 4);
        check("b2b_count", int'(pend_count), 4);
        idle(4, 1'b1);

        // Overflow: 17 toggles, saturate at 15
        for (int i = 0; i < 17; i++) begin
            toggle(1'b0);
            if (i % 3 == 0) idle(1, 1'b0);
        end
        idle(4, 1'b0);
        check("ovf_count", int'(pend_count), 15);
        check("ovf_flag", int'(overflow), 1);
        cycle(tog_in, 1'b0, 1'b1, 1'b0);
        check("ovf_clr", int'(overflow), 0);
        check("ovf_clr_count", int'(pend_count), 15);
        idle(15, 1'b1);
        check("ovf_drain", int'(pend_count), 0);

        // Simultaneous inc and dec while full
        for (int i = 0; i < 15; i++) toggle(1'b0);
        idle(4, 1'b0);
        check("sim_full", int'(pend_count), 15);
        toggle(1'b0);                              // E0
        idle(1, 1'b0);                             // E0+1
        idle(1, 1'b1);                             // E0+2: inc and dec together
        idle(3, 1'b0);
        check("sim_count", int'(pend_count), 15);
        check("sim_ovf", int'(overflow), 0);

        // Mid-operation reset with pend_count=6, overflow=1
        toggle(1'b0);
        idle(4, 1'b0);
        idle(9, 1'b1);
        check("pre_rst_count", int'(pend_count), 6);
        check("pre_rst_ovf", int'(overflow), 1);
        cycle(1'b1, 1'b0, 1'b0, 1'b1);
        check("mid_rst_count", int'(pend_count), 0);
        check("mid_rst_ovf", int'(overflow), 0);
        check("mid_rst_level_n", int'(tog_level_n), 1);
        pulses_seen = 0;
        idle(6, 1'b0);
        check("post_rst_pulses", pulses_seen, 1);
        check("post_rst_count", int'(pend_count), 1);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 2) == 0) ? !tog_in : tog_in,
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 40) == 0),
                  ($urandom_range(0, 500) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_toggle_decoder
